// File: rtl/dkong3_obj_dma.sv
// dkong3_obj_dma: double-buffered sprite table DMA from CPU RAM into object RAM; OBJ_DMA_ABORT_EN adds I_ABORT
module dkong3_obj_dma #(
  parameter int XFER_LEN = 384,
  parameter logic [7:0] SRC_LO = 8'h00
) (
  input  logic        I_CLK_12M,
  input  logic        RST_4L,
  input  logic        I_START,
  input  logic [7:0]  I_SRC_HI,
  input  logic        I_2PSL,
  input  logic        I_BUSAKn,
  input  logic [7:0]  I_MD,
`ifdef OBJ_DMA_ABORT_EN
  input  logic        I_ABORT,
`endif
  output logic        O_BUSRQn,
  output logic [15:0] O_MA,
  output logic        O_MRDn,
  output logic [9:0]  O_OBJ_DMA_A,
  output logic [7:0]  O_OBJ_DMA_D,
  output logic        O_OBJ_DMA_CE,
  output logic        O_BUSY,
  output logic        O_DONE
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, RD0 = 3'd2, RD1 = 3'd3, WR = 3'd4, REL = 3'd5;
  logic [2:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [15:0] src_q, src_d, ma_q, ma_d;
  logic bank_q, bank_d, aborted_q, aborted_d;
  logic [9:0] a_q, a_d;
  logic [7:0] d_q, d_d;
  logic abort, ack, last, go;
`ifdef OBJ_DMA_ABORT_EN
  assign abort = I_ABORT;
`else
  assign abort = 1'b0;
`endif
  assign ack = ~I_BUSAKn;
  assign last = cnt_q == 9'(XFER_LEN - 1);
  assign go = ack & ~abort;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_d = src_q;
    bank_d = bank_q;
    ma_d = ma_q;
    a_d = a_q;
    d_d = d_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: if (I_START) begin
        state_d = REQ;
        src_d = {I_SRC_HI, SRC_LO};
        bank_d = ~I_2PSL;
        cnt_d = '0;
        aborted_d = 1'b0;
      end
      REQ: begin
        state_d = abort ? REL : ack ? RD0 : REQ;
        aborted_d = abort;
        ma_d = go ? src_q + 16'(cnt_q) : ma_q;
      end
      RD0: begin
        state_d = abort ? REL : ack ? RD1 : REQ;
        aborted_d = abort;
      end
      RD1: begin
        state_d = abort ? REL : ack ? WR : REQ;
        aborted_d = abort;
        d_d = go ? I_MD : d_q;
        a_d = go ? {bank_q, cnt_q} : a_q;
      end
      WR: begin
        state_d = abort ? REL : !ack ? REQ : last ? REL : RD0;
        aborted_d = abort;
        cnt_d = (go && !last) ? cnt_q + 9'd1 : cnt_q;
        ma_d = (go && !last) ? src_q + 16'(cnt_q + 9'd1) : ma_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge I_CLK_12M or negedge RST_4L)
    if (!RST_4L) begin
      state_q <= IDLE;
      cnt_q <= '0;
      src_q <= '0;
      bank_q <= 1'b0;
      ma_q <= '0;
      a_q <= '0;
      d_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      bank_q <= bank_d;
      ma_q <= ma_d;
      a_q <= a_d;
      d_q <= d_d;
      aborted_q <= aborted_d;
    end
  assign O_BUSRQn = !(state_q inside {REQ, RD0, RD1, WR});
  assign O_MRDn = !((state_q inside {RD0, RD1}) && ack);
  assign O_OBJ_DMA_CE = state_q == WR && ack;
  assign O_BUSY = state_q != IDLE;
  assign O_DONE = state_q == REL && !aborted_q;
  assign O_MA = ma_q;
  assign O_OBJ_DMA_A = a_q;
  assign O_OBJ_DMA_D = d_q;
endmodule

// File: tb/tb_dkong3_obj_dma.sv
// tb_dkong3_obj_dma: randomized self-checking bench against a byte-list model of the sprite DMA
module tb_dkong3_obj_dma;
  localparam int N = 384;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, psl, busakn, busrqn, mrdn, ce, busy, done;
  logic [7:0] src_hi, md, d;
  logic [15:0] ma;
  logic [9:0] a;
  logic w_start, w_psl, w_busakn, w_busrqn, w_mrdn, w_ce, w_busy, w_done;
  logic [7:0] w_md, w_d;
  logic [15:0] w_ma;
  logic [9:0] w_a;
`ifdef OBJ_DMA_ABORT_EN
  logic abort;
`endif
  logic [7:0] mem [0:65535];
  assign md = mem[ma];
  assign w_md = mem[w_ma];
  dkong3_obj_dma dut (
    .I_CLK_12M(clk), .RST_4L(rst_n), .I_START(start), .I_SRC_HI(src_hi), .I_2PSL(psl),
    .I_BUSAKn(busakn), .I_MD(md),
`ifdef OBJ_DMA_ABORT_EN
    .I_ABORT(abort),
`endif
    .O_BUSRQn(busrqn), .O_MA(ma), .O_MRDn(mrdn), .O_OBJ_DMA_A(a), .O_OBJ_DMA_D(d),
    .O_OBJ_DMA_CE(ce), .O_BUSY(busy), .O_DONE(done)
  );
  dkong3_obj_dma #(.XFER_LEN(4), .SRC_LO(8'hFE)) u_wrap (
    .I_CLK_12M(clk), .RST_4L(rst_n), .I_START(w_start), .I_SRC_HI(8'hFF), .I_2PSL(w_psl),
    .I_BUSAKn(w_busakn), .I_MD(w_md),
`ifdef OBJ_DMA_ABORT_EN
    .I_ABORT(1'b0),
`endif
    .O_BUSRQn(w_busrqn), .O_MA(w_ma), .O_MRDn(w_mrdn), .O_OBJ_DMA_A(w_a), .O_OBJ_DMA_D(w_d),
    .O_OBJ_DMA_CE(w_ce), .O_BUSY(w_busy), .O_DONE(w_done)
  );
  int checks = 0, failures = 0;
  int cyc = 0, rq_cnt = 0, ack_delay = 2, hold = 0;
  int ack_cyc, done_cyc, done_n, win_ce;
  int loss_at, flip_at, restart_at;
  bit loss_done, flip_done, restart_done, start_req, in_win, prev_mrdn;
  logic [17:0] got [$];
  task automatic clear();
    got.delete();
    done_n = 0;
    done_cyc = -1;
    ack_cyc = -1;
    win_ce = 0;
    hold = 0;
    loss_at = -1;
    flip_at = -1;
    restart_at = -1;
    loss_done = 0;
    flip_done = 0;
    restart_done = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    start = start_req;
    start_req = 0;
    if (restart_at == got.size() && !restart_done && busy) begin
      start = 1'b1;
      src_hi = 8'h60;
      restart_done = 1;
    end
    if (flip_at == got.size() && !flip_done) begin
      psl = ~psl;
      flip_done = 1;
    end
    in_win = 0;
    if (busrqn) begin
      rq_cnt = 0;
      busakn = 1'b1;
    end else begin
      rq_cnt++;
      if (hold > 0) begin
        hold--;
        in_win = 1;
        busakn = 1'b1;
      end else begin
        if (busakn && rq_cnt >= ack_delay && ack_cyc < 0) ack_cyc = cyc;
        busakn = rq_cnt < ack_delay;
      end
    end
    @(negedge clk);
    if (ce) begin
      got.push_back({a, d});
      if (in_win) win_ce++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (loss_at == got.size() && !mrdn && prev_mrdn && !loss_done) begin
      hold = 5;
      loss_done = 1;
    end
    prev_mrdn = mrdn;
  endtask
  task automatic wait_done(input int max);
    int n = 0;
    while (done_n == 0 && n < max) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask
  task automatic launch(input logic [7:0] hi, input logic p);
    clear();
    src_hi = hi;
    psl = p;
    start_req = 1;
    tick();
  endtask
  function automatic int seq_bad(input logic [15:0] src, input logic bank, output int first);
    int bad = 0;
    logic [17:0] e;
    first = -1;
    for (int i = 0; i < got.size(); i++) begin
      e = {bank, 9'(i), mem[src + 16'(i)]};
      if (got[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    return bad;
  endfunction
  task automatic test_reset();
    checks++;
    if ({busrqn, mrdn, ce, busy, done} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_ctl: got %b exp 11000", {busrqn, mrdn, ce, busy, done});
    end
    checks++;
    if ({ma, a, d} !== 34'd0) begin
      failures++;
      $display("FAIL reset_regs: ma=%h a=%h d=%h exp 0", ma, a, d);
    end
    checks++;
    if ({w_busrqn, w_mrdn, w_ce, w_busy, w_done} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_wrap: got %b exp 11000", {w_busrqn, w_mrdn, w_ce, w_busy, w_done});
    end
  endtask
  task automatic check_xfer(input string nm, input logic [15:0] src, input logic bank, input bit timing);
    int bad, first;
    checks++;
    if (got.size() != N) begin
      failures++;
      $display("FAIL %s_count: got %0d CE exp %0d", nm, got.size(), N);
    end
    bad = seq_bad(src, bank, first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_data: %0d bad, first idx %0d got a=%h d=%h exp a=%h d=%h", nm, bad, first,
               got[first][17:8], got[first][7:0], {bank, 9'(first)}, mem[src + 16'(first)]);
    end
    checks++;
    if (done_n != 1) begin
      failures++;
      $display("FAIL %s_done: got %0d pulses exp 1", nm, done_n);
    end
    checks++;
    if ({busrqn, busy} !== 2'b10) begin
      failures++;
      $display("FAIL %s_release: busrqn,busy got %b exp 10", nm, {busrqn, busy});
    end
    if (timing) begin
      checks++;
      if (done_cyc - ack_cyc != 3 * N + 1) begin
        failures++;
        $display("FAIL %s_latency: got %0d exp %0d", nm, done_cyc - ack_cyc, 3 * N + 1);
      end
    end
  endtask
  task automatic test_basic();
    launch(8'h70, 1'b0);
    checks++;
    if ({busrqn, busy} !== 2'b10) begin
      failures++;
      $display("FAIL start_edge: busrqn,busy got %b exp 10", {busrqn, busy});
    end
    tick();
    checks++;
    if ({busrqn, busy} !== 2'b01) begin
      failures++;
      $display("FAIL start_next: busrqn,busy got %b exp 01", {busrqn, busy});
    end
    wait_done(5000);
    check_xfer("basic", 16'h7000, 1'b1, 1);
  endtask
  task automatic test_bank();
    launch(8'($urandom), 1'b1);
    flip_at = 100;
    wait_done(5000);
    check_xfer("bank", {src_hi, 8'h00}, 1'b0, 1);
  endtask
  task automatic test_bus_loss();
    int hits = 0;
    launch(8'h70, 1'b0);
    loss_at = 50;
    wait_done(5000);
    foreach (got[i]) if (got[i][17:8] == 10'h232) hits++;
    checks++;
    if (!loss_done || win_ce != 0) begin
      failures++;
      $display("FAIL loss_window: triggered=%0d ce_in_window=%0d exp 1/0", loss_done, win_ce);
    end
    checks++;
    if (hits != 1) begin
      failures++;
      $display("FAIL loss_byte50: got %0d writes exp 1", hits);
    end
    check_xfer("loss", 16'h7000, 1'b1, 0);
  endtask
  task automatic test_back_to_back();
    launch(8'h70, 1'b0);
    restart_at = 10;
    wait_done(5000);
    check_xfer("busy_start", 16'h7000, 1'b1, 1);
    repeat (10) tick();
    checks++;
    if (!restart_done || busy !== 1'b0 || done_n != 1) begin
      failures++;
      $display("FAIL busy_restart: injected=%0d busy=%b done=%0d exp 1/0/1", restart_done, busy, done_n);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    logic [7:0] hi = 8'($urandom);
    logic p = 1'($urandom);
    launch(hi, p);
    while (got.size() < 200 && n < 5000) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busrqn, mrdn, ce, busy, done} !== 5'b11000 || done_n != 0) begin
      failures++;
      $display("FAIL reset_mid: ctl %b done_n %0d exp 11000/0", {busrqn, mrdn, ce, busy, done}, done_n);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    busakn = 1'b1;
    rq_cnt = 0;
    hi = 8'($urandom);
    launch(hi, ~p);
    wait_done(5000);
    check_xfer("after_reset", {hi, 8'h00}, p, 1);
  endtask
  task automatic test_random();
    logic [7:0] hi;
    logic p;
    for (int k = 0; k < 3; k++) begin
      hi = 8'($urandom);
      p = 1'($urandom);
      ack_delay = $urandom_range(1, 6);
      launch(hi, p);
      wait_done(5000);
      check_xfer("random", {hi, 8'h00}, ~p, 1);
    end
    ack_delay = 2;
  endtask
  task automatic test_wrap();
    logic [15:0] mas [$];
    logic [17:0] wr [$];
    int wd = 0;
    logic p = 1'($urandom);
    w_psl = p;
    w_busakn = 1'b0;
    @(posedge clk);
    #1;
    w_start = 1'b1;
    @(posedge clk);
    #1;
    w_start = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (w_ce) begin
        mas.push_back(w_ma);
        wr.push_back({w_a, w_d});
      end
      if (w_done) wd++;
    end
    checks++;
    if (mas.size() != 4 || wd != 1) begin
      failures++;
      $display("FAIL wrap_count: got %0d CE %0d done exp 4/1", mas.size(), wd);
    end
    for (int i = 0; i < mas.size(); i++) begin
      checks++;
      if (mas[i] !== 16'hFFFE + 16'(i) || wr[i] !== {~p, 9'(i), mem[16'hFFFE + 16'(i)]}) begin
        failures++;
        $display("FAIL wrap_byte%0d: got ma=%h a/d=%h exp ma=%h a/d=%h", i, mas[i], wr[i],
                 16'hFFFE + 16'(i), {~p, 9'(i), mem[16'hFFFE + 16'(i)]});
      end
    end
  endtask
`ifdef OBJ_DMA_ABORT_EN
  task automatic test_abort();
    ack_delay = 1000;
    launch(8'h70, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busrqn, done} !== 2'b10) begin
      failures++;
      $display("FAIL abort_release: busrqn,done got %b exp 10", {busrqn, done});
    end
    repeat (5) tick();
    checks++;
    if (got.size() != 0 || done_n != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet: ce=%0d done=%0d busy=%b exp 0/0/0", got.size(), done_n, busy);
    end
    ack_delay = 2;
  endtask
`endif
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n = 1'b0;
    start = 1'b0;
    start_req = 0;
    src_hi = 8'h00;
    psl = 1'b0;
    busakn = 1'b1;
    prev_mrdn = 1'b1;
    w_start = 1'b0;
    w_psl = 1'b0;
    w_busakn = 1'b1;
`ifdef OBJ_DMA_ABORT_EN
    abort = 1'b0;
`endif
    clear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_bank();
    test_bus_loss();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
`ifdef OBJ_DMA_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
